duram_fifo: RTL and testbench

//  Single-clock FIFO built on an inferred simple-dual-port RAM (RAM written and read on the same clock).

---
 rtl/duram_fifo_pkg.sv | 5 +
 rtl/duram_sc.sv | 32 +++
 rtl/duram_fifo.sv | 122 ++++++++++++
 tb/tb_duram_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/duram_fifo_pkg.sv
// rtl/duram_fifo_pkg.sv - default geometry shared by the duram FIFO slice
package duram_fifo_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
endpackage

// File: rtl/duram_sc.sv
// rtl/duram_sc.sv - inferred simple-dual-port RAM, registered read, read-old-data on collision
//  clk           single clock
//  we/waddr/wdata  write port
//  re/raddr      read enable/address; rdata updates only when re is high
//  rdata         registered read data (contents and rdata are not reset)
module duram_sc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Both ports in one block with non-blocking updates: a read of the
    // address being written returns the previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/duram_fifo.sv
// rtl/duram_fifo.sv - single-clock FWFT FIFO on an inferred simple-dual-port RAM
//  Clk, Reset_n (async active-low), Clr (sync flush, highest priority)
//  Wr_en/Wr_data -> Full, Almost_full
//  Rd_en (pop) -> Rd_data, Rd_valid, Almost_empty
//  Count (0..DEPTH), Overflow/Underflow (1-cycle pulses for rejected requests)
module duram_fifo
    import duram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Clr,
    input  logic                  Wr_en,
    input  logic [DATA_WIDTH-1:0] Wr_data,
    output logic                  Full,
    output logic                  Almost_full,
    input  logic                  Rd_en,
    output logic [DATA_WIDTH-1:0] Rd_data,
    output logic                  Rd_valid,
    output logic                  Almost_empty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

    if (ADDR_WIDTH < 2) begin : g_bad_addr_width
        $error("duram_fifo: ADDR_WIDTH must be >= 2");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
        $error("duram_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   ram_words;
    logic                  head_valid;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  issue;
    logic [DATA_WIDTH-1:0] ram_q;

    // The RAM's registered read output doubles as the FWFT head register,
    // which gives the two-edge write-to-visible latency.
    assign Full      = (count == DEPTH_C);
    assign wr_acc    = Wr_en & ~Full & ~Clr;
    assign rd_acc    = Rd_en & head_valid & ~Clr;
    // Count includes the head word; what remains is still unread in RAM.
    assign ram_words = count - {{ADDR_WIDTH{1'b0}}, head_valid};
    // Refill the head when it is empty or leaving this cycle.
    assign issue     = ~Clr & (ram_words != '0) & (~head_valid | rd_acc);

    duram_sc #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (Clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(Wr_data),
        .re   (issue),
        .raddr(rd_ptr),
        .rdata(ram_q)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head_valid  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (Clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head_valid  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= Wr_en & Full;
            underflow_q <= Rd_en & ~head_valid;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
            if (issue) begin
                head_valid <= 1'b1;
            end else if (rd_acc) begin
                head_valid <= 1'b0;
            end
        end
    end

    assign Count        = count;
    assign Rd_valid     = head_valid;
    assign Rd_data      = head_valid ? ram_q : '0;
    assign Almost_full  = (count >= AF_C);
    assign Almost_empty = (count <= AE_C);
    assign Overflow     = overflow_q;
    assign Underflow    = underflow_q;

endmodule

// File: tb/tb_duram_fifo.sv
// tb/tb_duram_fifo.sv - directed scoreboard bench for duram_fifo
module tb_duram_fifo;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Clr;
    logic        Wr_en;
    logic [31:0] Wr_data;
    logic        Full;
    logic        Almost_full;
    logic        Rd_en;
    logic [31:0] Rd_data;
    logic        Rd_valid;
    logic        Almost_empty;
    logic [5:0]  Count;
    logic        Overflow;
    logic        Underflow;

    int          checks = 0;
    int          errors = 0;
    int          m_count = 0;
    logic [31:0] sb[$];

    always #5 Clk = ~Clk;

    duram_fifo dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Clr         (Clr),
        .Wr_en       (Wr_en),
        .Wr_data     (Wr_data),
        .Full        (Full),
        .Almost_full (Almost_full),
        .Rd_en       (Rd_en),
        .Rd_data     (Rd_data),
        .Rd_valid    (Rd_valid),
        .Almost_empty(Almost_empty),
        .Count       (Count),
        .Overflow    (Overflow),
        .Underflow   (Underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, Count, 0);
        chk({tag, "_full"}, Full, 0);
        chk({tag, "_afull"}, Almost_full, 0);
        chk({tag, "_rvalid"}, Rd_valid, 0);
        chk({tag, "_rdata"}, Rd_data, 0);
        chk({tag, "_aempty"}, Almost_empty, 1);
        chk({tag, "_ovf"}, Overflow, 0);
        chk({tag, "_udf"}, Underflow, 0);
    endtask

    // One clock: drive, predict acceptance, pop/compare head on accepted read,
    // then check registered status after the edge. Entered and left at posedge+1.
    task automatic tick(input logic clr, input logic w, input logic [31:0] d, input logic r);
        logic wacc, racc, e_ovf, e_udf;
        logic [31:0] exp_word;
        Clr = clr; Wr_en = w; Wr_data = d; Rd_en = r;
        if (clr) begin
            wacc = 1'b0; racc = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
        end else begin
            wacc  = w && (m_count != 32);
            racc  = r && (Rd_valid === 1'b1);
            e_ovf = w && !wacc;
            e_udf = r && !racc;
        end
        if (racc) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 1, 0);
            end else begin
                exp_word = sb.pop_front();
                chk("rd_data", Rd_data, exp_word);
            end
        end
        if (wacc) sb.push_back(d);
        if (clr) begin
            sb.delete();
            m_count = 0;
        end else begin
            m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
        end
        @(posedge Clk); #1;
        chk("count", Count, m_count);
        chk("full", Full, m_count == 32);
        chk("almost_full", Almost_full, m_count >= 30);
        chk("almost_empty", Almost_empty, m_count <= 2);
        chk("overflow", Overflow, e_ovf);
        chk("underflow", Underflow, e_udf);
        Clr = 1'b0; Wr_en = 1'b0; Rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && m_count > 0; i++) tick(0, 0, 0, 1);
        chk("drain_count", Count, 0);
        chk("drain_rvalid", Rd_valid, 0);
    endtask

    initial begin
        Reset_n = 1'b0; Clr = 1'b0; Wr_en = 1'b0; Rd_en = 1'b0; Wr_data = '0;
        @(posedge Clk); #1;
        chk_reset_outputs("reset");
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // 1: single write latency
        tick(0, 1, 32'hA5A5_0001, 0);
        chk("t1_count_t1", Count, 1);
        chk("t1_rvalid_t1", Rd_valid, 0);
        tick(0, 0, 0, 0);
        chk("t1_rvalid_t2", Rd_valid, 1);
        chk("t1_rdata_t2", Rd_data, 32'hA5A5_0001);
        tick(0, 0, 0, 1);
        chk("t1_rvalid_after_pop", Rd_valid, 0);

        // 2: fill to full, then a rejected write
        for (int i = 0; i < 32; i++) tick(0, 1, i, 0);
        chk("t2_full", Full, 1);
        tick(0, 1, 32'hDEAD_BEEF, 0);
        chk("t2_overflow", Overflow, 1);
        tick(0, 0, 0, 0);
        chk("t2_overflow_clear", Overflow, 0);

        // 3: full with simultaneous write and read
        tick(0, 1, 32'h0000_0100, 1);
        chk("t3_count", Count, 31);
        chk("t3_full", Full, 0);
        chk("t3_overflow", Overflow, 1);
        tick(0, 1, 32'h0000_0101, 0);
        chk("t3_refill_count", Count, 32);
        drain();

        // 4: continuous streaming, no bubbles once primed
        for (int i = 0; i < 100; i++) begin
            if (i >= 2) chk("t4_no_bubble", Rd_valid, 1);
            tick(0, 1, 32'h1000 + i, 1);
        end
        drain();

        // 5: underflow on empty, then flush with 10 words stored
        tick(0, 0, 0, 1);
        chk("t5_underflow", Underflow, 1);
        for (int i = 0; i < 10; i++) tick(0, 1, 32'h5000 + i, 0);
        tick(1, 1, 32'h5FFF, 1);
        chk_reset_outputs("t5_clr");
        tick(0, 1, 32'h0000_0055, 0);
        tick(0, 0, 0, 0);
        chk("t5_post_clr_rdata", Rd_data, 32'h0000_0055);
        drain();

        // 6: async reset mid-operation
        for (int i = 0; i < 17; i++) tick(0, 1, 32'h6000 + i, 0);
        chk("t6_count17", Count, 17);
        #2 Reset_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        sb.delete();
        m_count = 0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        tick(0, 1, 32'h7777_0001, 0);
        tick(0, 1, 32'h7777_0002, 0);
        chk("t6_post_rvalid", Rd_valid, 1);
        chk("t6_post_rdata", Rd_data, 32'h7777_0001);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
